zone_mean_calc: RTL and testbench

//  Upstream feeder of the zone-mean FIFO port: computes per-zone average luma over a ZONE_COLS x ZONE_ROWS grid.

---
 rtl/zone_pkg.sv | 36 +++
 rtl/zone_scaler.sv | 59 +++++
 rtl/zone_mean_calc.sv | 188 ++++++++++++++++++
 tb/tb_zone_mean_calc.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zone_pkg.sv
// Shared state encoding, fixed widths and sizing helpers for the zone-mean path.
// Geometry defaults describe the 1080p / 8x5 grid; derived values are recomputed per instance.
package zone_pkg;

  localparam int IMG_W_DEF     = 1920;
  localparam int IMG_H_DEF     = 1080;
  localparam int ZONE_COLS_DEF = 8;
  localparam int ZONE_ROWS_DEF = 5;

  // Reciprocal is a Q0.RS fraction; one extra bit keeps 2^RS representable for 1-pixel zones.
  localparam int RS      = 32;
  localparam int RECIP_W = RS + 1;
  localparam int IDX_W   = 6;

  typedef enum logic [1:0] {
    WAIT_VS,
    ACCUM,
    SCALE,
    DUMP
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_sum_w(input int zone_w, input int zone_h);
    return $clog2(zone_w * zone_h * 255 + 1);
  endfunction

  function automatic logic [RECIP_W-1:0] calc_recip(input int area);
    logic [63:0] num;
    num = (64'd1 << RS) + 64'(area / 2);
    return RECIP_W'(num / 64'(area));
  endfunction

endpackage

// File: rtl/zone_scaler.sv
// Two-stage sum-to-mean scaler: multiply by the zone reciprocal, then round and saturate to 8 bits.
// Carries the column tag alongside the data so the caller knows where each result belongs.
module zone_scaler
  import zone_pkg::*;
#(
  parameter int                 SUM_W = 24,
  parameter int                 COL_W = 3,
  parameter logic [RECIP_W-1:0] RECIP = calc_recip(51840)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [COL_W-1:0] in_col,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  output logic [COL_W-1:0] out_col,
  output logic [7:0]       out_mean
);

  localparam int PROD_W = SUM_W + RECIP_W;
  localparam logic [PROD_W:0] RND = (PROD_W + 1)'(1) << (RS - 1);

  logic              v1;
  logic [COL_W-1:0]  col1;
  logic [PROD_W-1:0] prod_q;
  logic [PROD_W:0]   rounded;
  logic [PROD_W:0]   shifted;
  logic [7:0]        mean_sat;

  // NOTE: registered state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      col1   <= '0;
      prod_q <= '0;
    end else begin
      v1     <= in_valid;
      col1   <= in_col;
      prod_q <= PROD_W'(in_sum) * PROD_W'(RECIP);
    end
  end

  assign rounded  = {1'b0, prod_q} + RND;
  assign shifted  = rounded >> RS;
  assign mean_sat = (|shifted[PROD_W:8]) ? 8'hFF : shifted[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_col   <= '0;
      out_mean  <= '0;
    end else begin
      out_valid <= v1;
      out_col   <= col1;
      out_mean  <= mean_sat;
    end
  end

endmodule

// File: rtl/zone_mean_calc.sv
// Per-zone average luma: accumulates one zone row at a time, scales it into a mean buffer,
// and emits all zone means as one contiguous burst per frame.
module zone_mean_calc
  import zone_pkg::*;
#(
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF,
  parameter int ZONE_COLS = ZONE_COLS_DEF,
  parameter int ZONE_ROWS = ZONE_ROWS_DEF,
  parameter bit VS_POL    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vs_in,
  input  logic             de_in,
  input  logic [7:0]       luma_in,
  output logic             mean_valid,
  output logic [7:0]       mean_out,
  output logic [IDX_W-1:0] zone_idx,
  output logic             frame_err
);

  localparam int ZONE_W  = IMG_W / ZONE_COLS;
  localparam int ZONE_H  = IMG_H / ZONE_ROWS;
  localparam int N_ZONES = ZONE_COLS * ZONE_ROWS;
  localparam int SUM_W   = calc_sum_w(ZONE_W, ZONE_H);
  localparam logic [RECIP_W-1:0] RECIP = calc_recip(ZONE_W * ZONE_H);
  localparam int COL_W = cnt_w(ZONE_COLS);
  localparam int PX_W  = cnt_w(ZONE_W);
  localparam int LY_W  = cnt_w(ZONE_H);
  localparam int ROW_W = cnt_w(ZONE_ROWS);
  localparam int SC_W  = cnt_w(ZONE_COLS + 2);

  state_t state, state_nxt;

  logic             vs_act, vs_prev, de_prev;
  logic             frame_start, de_fall, start_pend, restart;
  logic             pix_ok, row_end, issue, scale_done, dump_done;
  logic [COL_W-1:0] cx, scol;
  logic [PX_W-1:0]  px;
  logic [LY_W-1:0]  ly;
  logic [ROW_W-1:0] row;
  logic             line_done;
  logic [SC_W-1:0]  sc;
  logic [IDX_W-1:0] rd, buf_wr_idx;
  logic [SUM_W-1:0] acc [ZONE_COLS];
  logic [7:0]       mean_buf [N_ZONES];
  logic             sc_valid;
  logic [COL_W-1:0] sc_col;
  logic [7:0]       sc_mean;

  assign vs_act      = (vs_in == VS_POL);
  assign frame_start = vs_act & ~vs_prev;
  assign de_fall     = de_prev & ~de_in;
  assign pix_ok      = (state == ACCUM) && de_in && !line_done;
  assign row_end     = pix_ok && (cx == COL_W'(ZONE_COLS - 1)) && (px == PX_W'(ZONE_W - 1))
                       && (ly == LY_W'(ZONE_H - 1));
  assign issue       = (state == SCALE) && (sc < SC_W'(ZONE_COLS));
  assign scale_done  = (state == SCALE) && (sc == SC_W'(ZONE_COLS + 1));
  assign dump_done   = (state == DUMP) && (rd == IDX_W'(N_ZONES - 1));
  assign scol        = sc[COL_W-1:0];
  assign buf_wr_idx  = IDX_W'(row) * IDX_W'(ZONE_COLS) + IDX_W'(sc_col);
  // A frame start seen during the burst is held and taken once the burst has drained.
  assign restart     = (frame_start && state != DUMP) || (dump_done && (start_pend || frame_start));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_VS;
    else     state <= state_nxt;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_VS: if (frame_start) state_nxt = ACCUM;
      ACCUM:   if (!frame_start && row_end) state_nxt = SCALE;
      SCALE: begin
        if (frame_start)     state_nxt = ACCUM;
        else if (scale_done) state_nxt = (row == ROW_W'(ZONE_ROWS - 1)) ? DUMP : ACCUM;
      end
      DUMP:    if (dump_done) state_nxt = (start_pend || frame_start) ? ACCUM : WAIT_VS;
      default: state_nxt = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev    <= 1'b1;
      de_prev    <= 1'b0;
      start_pend <= 1'b0;
      frame_err  <= 1'b0;
      sc         <= '0;
      rd         <= '0;
    end else begin
      vs_prev    <= vs_act;
      de_prev    <= de_in;
      start_pend <= (state == DUMP) && !dump_done && (start_pend || frame_start);
      if (frame_start)                   frame_err <= 1'b0;
      else if (state == SCALE && de_in)  frame_err <= 1'b1;
      sc <= (state == SCALE && state_nxt == SCALE) ? sc + 1'b1 : '0;
      rd <= (state == DUMP && state_nxt == DUMP) ? rd + 1'b1 : '0;
    end
  end

  // Position tracking: px/cx walk the line and stop at IMG_W, ly/row track lines within the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx        <= '0;
      px        <= '0;
      ly        <= '0;
      row       <= '0;
      line_done <= 1'b0;
    end else if (restart) begin
      cx        <= '0;
      px        <= '0;
      ly        <= '0;
      row       <= '0;
      line_done <= 1'b0;
    end else begin
      if (pix_ok) begin
        if (px == PX_W'(ZONE_W - 1)) begin
          px <= '0;
          if (cx == COL_W'(ZONE_COLS - 1)) line_done <= 1'b1;
          else                             cx <= cx + 1'b1;
        end else begin
          px <= px + 1'b1;
        end
      end
      if (de_fall && (state == ACCUM || state == SCALE)) begin
        cx        <= '0;
        px        <= '0;
        line_done <= 1'b0;
        ly        <= (ly == LY_W'(ZONE_H - 1)) ? '0 : ly + 1'b1;
      end
      if (scale_done && row != ROW_W'(ZONE_ROWS - 1)) row <= row + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ZONE_COLS; i++) acc[i] <= '0;
    end else if (restart) begin
      for (int i = 0; i < ZONE_COLS; i++) acc[i] <= '0;
    end else begin
      if (pix_ok) acc[cx] <= acc[cx] + SUM_W'(luma_in);
      if (issue)  acc[scol] <= '0;
    end
  end

  zone_scaler #(
    .SUM_W (SUM_W),
    .COL_W (COL_W),
    .RECIP (RECIP)
  ) u_scaler (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_col    (scol),
    .in_sum    (acc[scol]),
    .out_valid (sc_valid),
    .out_col   (sc_col),
    .out_mean  (sc_mean)
  );

  // NOTE: the mean buffer is a small flop array, so it is cleared on reset like any other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ZONES; i++) mean_buf[i] <= '0;
    end else if (state == SCALE && sc_valid) begin
      mean_buf[buf_wr_idx] <= sc_mean;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mean_valid <= 1'b0;
      mean_out   <= '0;
      zone_idx   <= '0;
    end else begin
      mean_valid <= (state == DUMP);
      if (state == DUMP) begin
        mean_out <= mean_buf[rd];
        zone_idx <= rd;
      end
    end
  end

endmodule

// File: tb/tb_zone_mean_calc.sv
// Directed bench for zone_mean_calc on a 16x10 image (8x5 grid of 2x2 zones, 4 pixels per zone).
// A negedge monitor records every burst entry; each test compares against hand-derived means.
module tb_zone_mean_calc;

  localparam int W   = 16;
  localparam int H   = 10;
  localparam int CAP = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs_in = 1'b0;
  logic       de_in = 1'b0;
  logic [7:0] luma_in = '0;
  logic       mean_valid;
  logic [7:0] mean_out;
  logic [5:0] zone_idx;
  logic       frame_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] cap_val [CAP];
  logic [5:0] cap_idx [CAP];
  int         cap_n = 0;
  int         runs = 0;
  bit         prev_valid = 1'b0;

  zone_mean_calc #(
    .IMG_W     (W),
    .IMG_H     (H),
    .ZONE_COLS (8),
    .ZONE_ROWS (5),
    .VS_POL    (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vs_in      (vs_in),
    .de_in      (de_in),
    .luma_in    (luma_in),
    .mean_valid (mean_valid),
    .mean_out   (mean_out),
    .zone_idx   (zone_idx),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mean_valid === 1'b1) begin
      if (cap_n < CAP) begin
        cap_val[cap_n] = mean_out;
        cap_idx[cap_n] = zone_idx;
      end
      cap_n++;
      if (!prev_valid) runs++;
    end
    prev_valid = (mean_valid === 1'b1);
  end

  // mode 0: flat val; 1: zone z gets 5*z; 2: zone 0 checkerboard 255/0, rest 0; 3: all 255
  function automatic logic [7:0] pix(input int mode, input int val, input int x, input int y);
    int z;
    z = (y / 2) * 8 + x / 2;
    case (mode)
      0:       return 8'(val);
      1:       return 8'(5 * z);
      2:       return (x < 2 && y < 2 && ((x + y) % 2 == 0)) ? 8'd255 : 8'd0;
      default: return 8'd255;
    endcase
  endfunction

  function automatic logic [7:0] exp_mean(input int mode, input int val, input int z);
    case (mode)
      0:       return 8'(val);
      1:       return 8'(5 * z);
      2:       return (z == 0) ? 8'd128 : 8'd0;
      default: return 8'd255;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    vs_in = 1'b1;
    repeat (2) tick();
    vs_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_lines(input int mode, input int val, input int bad_line);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        de_in   = 1'b1;
        luma_in = pix(mode, val, x, y);
        tick();
      end
      de_in   = 1'b0;
      luma_in = '0;
      repeat ((y == bad_line) ? 4 : 12) tick();
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    tests_run++;
    if (mean_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", mean_valid); end
    tests_run++;
    if (mean_out !== 8'd0) begin tests_failed++; $display("FAIL reset_mean: got %0d expected 0", mean_out); end
    tests_run++;
    if (zone_idx !== 6'd0) begin tests_failed++; $display("FAIL reset_idx: got %0d expected 0", zone_idx); end
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_no_vs();
    int b;
    b = cap_n;
    send_lines(0, 90, -1);
    repeat (70) tick();
    tests_run++;
    if (cap_n != b) begin tests_failed++; $display("FAIL no_vs_burst: got %0d entries expected 0", cap_n - b); end
  endtask

  task automatic test_flat();
    int b, r;
    b = cap_n;
    r = runs;
    vs_pulse();
    send_lines(0, 100, -1);
    repeat (70) tick();
    tests_run++;
    if (cap_n - b != 40) begin tests_failed++; $display("FAIL flat_count: got %0d expected 40", cap_n - b); end
    tests_run++;
    if (runs - r != 1) begin tests_failed++; $display("FAIL flat_contig: got %0d runs expected 1", runs - r); end
    for (int i = 0; i < 40; i++) begin
      tests_run++;
      if (cap_val[b+i] !== 8'd100 || cap_idx[b+i] !== 6'(i)) begin
        tests_failed++;
        $display("FAIL flat_entry%0d: got mean %0d idx %0d expected mean 100 idx %0d", i, cap_val[b+i], cap_idx[b+i], i);
      end
    end
    tests_run++;
    if (mean_valid !== 1'b0 || mean_out !== 8'd100 || zone_idx !== 6'd39) begin
      tests_failed++;
      $display("FAIL flat_hold: got valid %b mean %0d idx %0d expected 0/100/39", mean_valid, mean_out, zone_idx);
    end
  endtask

  task automatic test_patterns();
    int b, r;
    for (int mode = 1; mode <= 3; mode++) begin
      b = cap_n;
      r = runs;
      vs_pulse();
      send_lines(mode, 0, -1);
      repeat (70) tick();
      tests_run++;
      if (cap_n - b != 40 || runs - r != 1) begin
        tests_failed++;
        $display("FAIL pat%0d_count: got %0d entries in %0d runs expected 40 in 1", mode, cap_n - b, runs - r);
      end
      for (int i = 0; i < 40; i++) begin
        tests_run++;
        if (cap_val[b+i] !== exp_mean(mode, 0, i) || cap_idx[b+i] !== 6'(i)) begin
          tests_failed++;
          $display("FAIL pat%0d_entry%0d: got mean %0d idx %0d expected mean %0d idx %0d",
                   mode, i, cap_val[b+i], cap_idx[b+i], exp_mean(mode, 0, i), i);
        end
      end
    end
  endtask

  task automatic test_frame_err();
    int b;
    vs_pulse();
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL err_start: got %b expected 0", frame_err); end
    send_lines(0, 60, 1);
    repeat (70) tick();
    tests_run++;
    if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL err_short_hblank: got %b expected 1", frame_err); end
    vs_pulse();
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL err_clear: got %b expected 0", frame_err); end
    b = cap_n;
    send_lines(0, 60, -1);
    repeat (70) tick();
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL err_legal: got %b expected 0", frame_err); end
    tests_run++;
    if (cap_n - b != 40 || cap_val[b] !== 8'd60 || cap_val[b+39] !== 8'd60) begin
      tests_failed++;
      $display("FAIL err_recover: got %0d entries first %0d last %0d expected 40 of 60", cap_n - b, cap_val[b], cap_val[b+39]);
    end
  endtask

  task automatic test_reset_mid_dump();
    int b, r, n;
    b = cap_n;
    vs_pulse();
    send_lines(0, 77, -1);
    n = 0;
    while (cap_n < b + 10 && n < 200) begin
      tick();
      n++;
    end
    tests_run++;
    if (cap_n < b + 10) begin tests_failed++; $display("FAIL rst_dump_wait: got %0d entries expected 10 within 200 cycles", cap_n - b); end
    rst = 1'b1;
    #1;
    tests_run++;
    if (mean_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_dump_valid: got %b expected 0", mean_valid); end
    tests_run++;
    if (mean_out !== 8'd0) begin tests_failed++; $display("FAIL rst_dump_mean: got %0d expected 0", mean_out); end
    tick();
    rst = 1'b0;
    tick();
    b = cap_n;
    send_lines(0, 77, -1);
    repeat (70) tick();
    tests_run++;
    if (cap_n != b) begin tests_failed++; $display("FAIL rst_no_resume: got %0d entries expected 0", cap_n - b); end
    r = runs;
    vs_pulse();
    send_lines(0, 33, -1);
    repeat (70) tick();
    tests_run++;
    if (cap_n - b != 40 || runs - r != 1) begin
      tests_failed++;
      $display("FAIL rst_next_count: got %0d entries in %0d runs expected 40 in 1", cap_n - b, runs - r);
    end
    for (int i = 0; i < 40; i += 13) begin
      tests_run++;
      if (cap_val[b+i] !== 8'd33 || cap_idx[b+i] !== 6'(i)) begin
        tests_failed++;
        $display("FAIL rst_next_entry%0d: got mean %0d idx %0d expected mean 33 idx %0d", i, cap_val[b+i], cap_idx[b+i], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int b, r;
    b = cap_n;
    r = runs;
    vs_pulse();
    send_lines(1, 0, -1);
    vs_pulse();
    repeat (60) tick();
    send_lines(0, 50, -1);
    repeat (70) tick();
    tests_run++;
    if (cap_n - b != 80 || runs - r != 2) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d entries in %0d runs expected 80 in 2", cap_n - b, runs - r);
    end
    for (int i = 0; i < 40; i += 7) begin
      tests_run++;
      if (cap_val[b+i] !== exp_mean(1, 0, i) || cap_val[b+40+i] !== 8'd50 || cap_idx[b+40+i] !== 6'(i)) begin
        tests_failed++;
        $display("FAIL b2b_entry%0d: got %0d then %0d expected %0d then 50",
                 i, cap_val[b+i], cap_val[b+40+i], exp_mean(1, 0, i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_vs();
    test_flat();
    test_patterns();
    test_frame_err();
    test_reset_mid_dump();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
